// File: rtl/iobus_uart_pkg.sv
// Shared definitions for the iobus_uart slave: register offsets, STATUS bit
// positions, FSM state encodings and the divisor floor.
package iobus_uart_pkg;

  localparam logic [11:0] OFS_DATA   = 12'h000;
  localparam logic [11:0] OFS_STATUS = 12'h004;
  localparam logic [11:0] OFS_BAUD   = 12'h008;
  localparam logic [11:0] OFS_RXDATA = 12'h00C;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_RXV     = 4;
  localparam int ST_RXOVR   = 5;
  localparam int ST_LVL_LSB = 8;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below MIN_DIV would leave no room for mid-bit sampling.
  function automatic logic [15:0] eff_div(input logic [15:0] baud);
    return (baud < MIN_DIV) ? MIN_DIV : baud;
  endfunction

endpackage

// File: rtl/iobus_uart_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port; a push is accepted
// when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/iobus_uart.sv
// MicroBlaze MCS IO-bus 8N1 UART slave with a buffered transmitter.
// Optional receiver compiled in with IOBUS_UART_RX_EN.
module iobus_uart
  import iobus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'hC0003000,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] CLK_DIV      = 16'd434
) (
  input  logic        io_clk,
  input  logic        io_rst,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_address,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        uart_tx
`ifdef IOBUS_UART_RX_EN
  ,input  logic       uart_rx
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             hit, wr, rd, push, pop, ovf_set;
  logic [11:0]      offs;
  logic             ready_q, ovf_q, tx_q;
  logic [31:0]      rdata_q, rdata_d, status;
  logic [15:0]      baud_q, eff, cnt_q;
  logic [7:0]       shift_q;
  logic [2:0]       idx_q;
  tx_state_e        tx_state_q;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             rx_valid, rx_overrun;
  logic [7:0]       rx_data;
  logic             unused_ok;

  assign unused_ok = ^{io_write_data[31:16], io_byte_enable[3:2]};

  assign hit  = io_addr_strobe && (io_address[31:12] == BASE_ADDRESS[31:12]);
  assign wr   = hit && io_write_strobe;
  assign rd   = hit && io_read_strobe;
  assign offs = io_address[11:0];
  assign eff  = eff_div(baud_q);

  assign push    = wr && (offs == OFS_DATA) && io_byte_enable[0];
  // The shifter pops in IDLE or at the very end of STOP so frames chain without a gap.
  assign pop     = !fifo_empty &&
                   ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && (cnt_q == '0)));
  assign ovf_set = push && fifo_full && !pop;

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_txfifo (
    .clk_i   (io_clk),
    .rst_i   (io_rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (io_write_data[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = (tx_state_q != TX_IDLE);
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_OVF]       = ovf_q;
    status[ST_RXV]       = rx_valid;
    status[ST_RXOVR]     = rx_overrun;
    status[ST_LVL_LSB +: 8] = 8'(fifo_level);
  end

  always_comb begin
    rdata_d = '0;
    case (offs)
      OFS_STATUS: rdata_d = status;
      OFS_BAUD:   rdata_d = {16'h0000, baud_q};
      OFS_RXDATA: rdata_d = {24'h000000, rx_data};
      default:    rdata_d = '0;
    endcase
  end

  // Bus response and register file
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      baud_q  <= CLK_DIV;
      ovf_q   <= 1'b0;
    end else begin
      ready_q <= hit;
      rdata_q <= rd ? rdata_d : '0;
      if (wr && (offs == OFS_BAUD)) begin
        if (io_byte_enable[0]) baud_q[7:0]  <= io_write_data[7:0];
        if (io_byte_enable[1]) baud_q[15:8] <= io_write_data[15:8];
      end
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (rd && (offs == OFS_STATUS))
        ovf_q <= 1'b0;
    end
  end

  assign io_ready     = ready_q;
  assign io_read_data = rdata_q;
  assign uart_tx      = tx_q;

  // Transmit shifter
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q    <= fifo_dout;
            tx_q       <= 1'b0;
            cnt_q      <= eff - 16'd1;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == '0) begin
            tx_q       <= shift_q[0];
            shift_q    <= shift_q >> 1;
            idx_q      <= '0;
            cnt_q      <= eff - 16'd1;
            tx_state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= eff - 16'd1;
            if (idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (cnt_q == '0) begin
            if (pop) begin
              shift_q    <= fifo_dout;
              tx_q       <= 1'b0;
              cnt_q      <= eff - 16'd1;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

`ifdef IOBUS_UART_RX_EN
  logic        rx_meta_q, rx_sync_q, rx_valid_q, rx_ovr_q;
  logic [7:0]  rx_data_q, rx_shift_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  rx_state_e   rx_state_q;

  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_ovr_q;
  assign rx_data    = rx_data_q;

  // Receiver: half-bit wait after the falling edge, then full-bit steps land mid-bit
  always_ff @(posedge io_clk) begin
    if (io_rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_state_q <= RX_IDLE;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      if (rd && (offs == OFS_STATUS)) rx_ovr_q   <= 1'b0;
      if (rd && (offs == OFS_RXDATA)) rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_cnt_q   <= (eff >> 1) - 16'd1;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            rx_cnt_q   <= eff - 16'd1;
            rx_idx_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= eff - 16'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) begin
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q) rx_ovr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_data    = 8'h00;
`endif

endmodule
